// File: rtl/paillier_result_gather_if.sv
// Result-gather bundle: task-issue port, per-engine FIFO taps, tagged output stream, busy.
// The gather block is the master: it drives issue_rdy, the FIFO pops and the stream.
interface paillier_result_gather_if #(
  parameter int CH = 29,
  parameter int K  = 128,
  parameter int N  = 32
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW  = $clog2(N) + 1;

  logic              issue_vld;
  logic [CHW-1:0]    issue_ch;
  logic              issue_rdy;
  logic [CH*CW-1:0]  ch_cnt;
  logic [CH*K-1:0]   ch_dout;
  logic [CH-1:0]     ch_rd;
  logic [K-1:0]      m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [CHW-1:0]    m_tuser;
  logic              busy;

  modport master (
    input  issue_vld, issue_ch, ch_cnt, ch_dout, m_tready,
    output issue_rdy, ch_rd, m_tdata, m_tvalid, m_tlast, m_tuser, busy
  );

  modport slave (
    output issue_vld, issue_ch, ch_cnt, ch_dout, m_tready,
    input  issue_rdy, ch_rd, m_tdata, m_tvalid, m_tlast, m_tuser, busy
  );
endinterface

// File: rtl/paillier_result_gather.sv
// Streams complete N-word results from engine FIFOs as tagged packets; first beat 2 cycles after eligibility.
// One output register: FIFOs pop only when it can load, so m_tready low stalls pops and freezes the beat.
module paillier_result_gather #(
  parameter int CH       = 29,
  parameter int K        = 128,
  parameter int N        = 32,
  parameter int ORDERED  = 1,
  parameter int ID_DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  paillier_result_gather_if.master io
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW  = $clog2(N) + 1;
  localparam int QW  = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;

  typedef enum logic {SELECT, STREAM} state_t;

  state_t         state, state_nxt;
  logic [CHW-1:0] sel_ch, pick_ch, rr_ptr, rr_pick, q_head;
  logic [CW-1:0]  beat;
  logic           eligible, ord_elig, rr_found, advance, q_empty, q_rdy;
  logic [K-1:0]   tdata;
  logic           tvalid, tlast;
  logic [CHW-1:0] tuser;
  logic [CH-1:0]  ch_rd;
  logic [CW-1:0]  cnt  [CH];
  logic [K-1:0]   dout [CH];

  for (genvar c = 0; c < CH; c++) begin : g_unpack
    assign cnt[c]  = io.ch_cnt[c*CW +: CW];
    assign dout[c] = io.ch_dout[c*K +: K];
  end

  // Round-robin scan: first complete channel at or after rr_ptr, wrapping at CH.
  always_comb begin
    int j;
    j        = 0;
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 0; i < CH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= CH) j = j - CH;
      if (!rr_found && cnt[j] >= CW'(N)) begin
        rr_found = 1'b1;
        rr_pick  = CHW'(j);
      end
    end
  end

  if (ORDERED != 0) begin : g_order_q
    logic [CHW-1:0] mem [ID_DEPTH];
    logic [QW-1:0]  wr_ptr, rd_ptr;
    logic [QW:0]    count, count_nxt;
    logic           push, pop;

    assign push     = io.issue_vld && q_rdy;
    assign pop      = (state == SELECT) && ord_elig;
    assign q_head   = mem[rd_ptr];
    assign q_empty  = (count == '0);
    assign ord_elig = !q_empty && (int'(q_head) < CH) && (cnt[q_head] >= CW'(N));

    always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + 1'b1;
      else if (!push && pop) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= io.issue_ch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        q_rdy  <= 1'b1;
      end else begin
        if (push) wr_ptr <= (wr_ptr == QW'(ID_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == QW'(ID_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
        count <= count_nxt;
        q_rdy <= (count_nxt != (QW+1)'(ID_DEPTH));
      end
    end
  end else begin : g_no_q
    logic unused_issue;
    assign unused_issue = ^{io.issue_vld, io.issue_ch};
    assign q_rdy    = 1'b1;
    assign q_empty  = 1'b1;
    assign q_head   = '0;
    assign ord_elig = 1'b0;
  end

  assign eligible = (ORDERED != 0) ? ord_elig : rr_found;
  assign pick_ch  = (ORDERED != 0) ? q_head : rr_pick;

  // The cnt guard never trips in legal use; it keeps an empty FIFO from being popped.
  assign advance = (state == STREAM) && (!tvalid || io.m_tready) &&
                   (beat < CW'(N)) && (cnt[sel_ch] != '0);

  always_comb begin
    state_nxt = state;
    ch_rd     = '0;
    case (state)
      SELECT: if (eligible) state_nxt = STREAM;
      STREAM: begin
        if (advance) ch_rd[sel_ch] = 1'b1;
        if (tvalid && io.m_tready && tlast) state_nxt = SELECT;
      end
      default: state_nxt = SELECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SELECT;
      sel_ch <= '0;
      rr_ptr <= '0;
      beat   <= '0;
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tuser  <= '0;
    end else begin
      state <= state_nxt;
      if (state == SELECT && eligible) begin
        sel_ch <= pick_ch;
        tuser  <= pick_ch;
        beat   <= '0;
        if (ORDERED == 0) rr_ptr <= (int'(pick_ch) == CH-1) ? '0 : pick_ch + 1'b1;
      end
      if (advance) begin
        tdata  <= dout[sel_ch];
        tvalid <= 1'b1;
        tlast  <= (beat == CW'(N-1));
        beat   <= beat + 1'b1;
      end else if (tvalid && io.m_tready) begin
        tvalid <= 1'b0;
      end
    end
  end

  assign io.issue_rdy = q_rdy;
  assign io.ch_rd     = ch_rd;
  assign io.m_tdata   = tdata;
  assign io.m_tvalid  = tvalid;
  assign io.m_tlast   = tlast;
  assign io.m_tuser   = tuser;
  assign io.busy      = (state == STREAM) || tvalid || !q_empty;
endmodule

// File: tb/tb_paillier_result_gather.sv
// Two instances (ordered / round-robin, CH=4 N=4 ID_DEPTH=4) fed by modelled engine FIFOs; scoreboard checks the streams.
module tb_paillier_result_gather;
  localparam int CH = 4, K = 32, N = 4, ID_DEPTH = 4, CW = 3;

  typedef struct packed { logic [31:0] d; logic last; logic [1:0] user; } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             issue_vld [2];
  logic [1:0]       issue_ch  [2];
  logic             issue_rdy [2];
  logic [CH*CW-1:0] ch_cnt    [2];
  logic [CH*K-1:0]  ch_dout   [2];
  logic [CH-1:0]    ch_rd     [2];
  logic [K-1:0]     m_tdata   [2];
  logic             m_tvalid  [2];
  logic             m_tready  [2];
  logic             m_tlast   [2];
  logic [1:0]       m_tuser   [2];
  logic             busy      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    paillier_result_gather_if #(.CH(CH), .K(K), .N(N)) io ();
    assign io.issue_vld = issue_vld[g];
    assign io.issue_ch  = issue_ch[g];
    assign io.ch_cnt    = ch_cnt[g];
    assign io.ch_dout   = ch_dout[g];
    assign io.m_tready  = m_tready[g];
    assign issue_rdy[g] = io.issue_rdy;
    assign ch_rd[g]     = io.ch_rd;
    assign m_tdata[g]   = io.m_tdata;
    assign m_tvalid[g]  = io.m_tvalid;
    assign m_tlast[g]   = io.m_tlast;
    assign m_tuser[g]   = io.m_tuser;
    assign busy[g]      = io.busy;
    paillier_result_gather #(.CH(CH), .K(K), .N(N), .ORDERED(g == 0 ? 1 : 0), .ID_DEPTH(ID_DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .io(io)
    );
  end

  logic [31:0]   fq [2][CH][$];
  beat_t         exp_q [2][$];
  int            seq  [2][CH] = '{default: 0};
  int            eseq [2][CH] = '{default: 0};
  int            rd_cnt [2]   = '{default: 0};
  logic [CH-1:0] rd_seen [2]  = '{default: '0};
  beat_t         mon_e;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(string name, bit ok, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] wd(int g, int c, int s);
    return 32'hCAFE_0000 | 32'(g << 12) | 32'(c << 8) | 32'(s);
  endfunction

  task automatic push_words(int g, int c, int n);
    for (int i = 0; i < n; i++) begin
      fq[g][c].push_back(wd(g, c, seq[g][c]));
      seq[g][c]++;
    end
  endtask

  task automatic expect_pkt(int g, int c);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.d    = wd(g, c, eseq[g][c]);
      b.last = (i == N-1);
      b.user = 2'(c);
      exp_q[g].push_back(b);
      eseq[g][c]++;
    end
  endtask

  task automatic discard(int g, int c);
    fq[g][c].delete();
    eseq[g][c] = seq[g][c];
  endtask

  task automatic refresh_all();
    for (int g = 0; g < 2; g++)
      for (int c = 0; c < CH; c++) begin
        ch_cnt[g][c*CW +: CW] = CW'(fq[g][c].size());
        ch_dout[g][c*K +: K]  = (fq[g][c].size() != 0) ? fq[g][c][0] : '0;
      end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic issue(int g, int c);
    chk("issue_rdy", issue_rdy[g] == 1'b1, 64'(issue_rdy[g]), 64'(1));
    issue_vld[g] = 1'b1;
    issue_ch[g]  = 2'(c);
    tick(1);
    issue_vld[g] = 1'b0;
  endtask

  task automatic wait_exp(int g, string name);
    int n;
    n = 0;
    while (exp_q[g].size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    chk(name, exp_q[g].size() == 0, 64'(exp_q[g].size()), 64'(0));
  endtask

  // Monitor and FIFO-output refresh: sample the pop strobe first, then update the FIFO view.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      rd_seen[g] = ch_rd[g];
      if (rst_n && m_tvalid[g] && m_tready[g]) begin
        if (exp_q[g].size() == 0) begin
          chk("unexpected_beat", 1'b0, 64'(m_tdata[g]), 64'(0));
        end else begin
          mon_e = exp_q[g].pop_front();
          chk("beat", {m_tdata[g], m_tlast[g], m_tuser[g]} == mon_e,
              64'({m_tdata[g], m_tlast[g], m_tuser[g]}), 64'(mon_e));
        end
      end
    end
    refresh_all();
  end

  // Engine FIFO model: a pop strobe seen before the edge removes the head the DUT just captured.
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      if ($countones(rd_seen[g]) > 1) chk("rd_onehot", 1'b0, 64'(rd_seen[g]), 64'(0));
      for (int c = 0; c < CH; c++) begin
        if (rd_seen[g][c]) begin
          rd_cnt[g]++;
          if (fq[g][c].size() == 0) chk("pop_empty", 1'b0, 64'(c), 64'(0));
          else void'(fq[g][c].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    int rd0, lat;
    bit got;
    pat = 4'b1001;
    for (int g = 0; g < 2; g++) begin
      issue_vld[g] = 1'b0;
      issue_ch[g]  = '0;
      m_tready[g]  = 1'b1;
    end
    tick(3);
    for (int g = 0; g < 2; g++)
      chk("reset_outputs",
          {issue_rdy[g], ch_rd[g], m_tvalid[g], m_tdata[g], m_tlast[g], m_tuser[g], busy[g]} == {1'b1, 41'b0},
          64'({issue_rdy[g], ch_rd[g], m_tvalid[g], m_tdata[g], m_tlast[g], m_tuser[g], busy[g]}),
          64'({1'b1, 41'b0}));
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // Ordered: ch0 completes first but ch2 was issued first, so nothing moves until ch2 is complete.
    issue(0, 2);
    issue(0, 0);
    push_words(0, 0, 4);
    tick(10);
    chk("no_overtake_fifo", fq[0][0].size() == 4, 64'(fq[0][0].size()), 64'(4));
    chk("no_overtake_valid", m_tvalid[0] == 1'b0, 64'(m_tvalid[0]), 64'(0));
    chk("busy_queued", busy[0] == 1'b1, 64'(busy[0]), 64'(1));
    expect_pkt(0, 2);
    expect_pkt(0, 0);
    rd0 = rd_cnt[0];
    push_words(0, 2, 4);
    for (int i = 0; i < 40; i++) begin
      m_tready[0] = pat[i % 4];
      tick(1);
    end
    m_tready[0] = 1'b1;
    wait_exp(0, "ordered_drain");
    tick(3);
    chk("rd_pulses", rd_cnt[0] - rd0 == 8, 64'(rd_cnt[0] - rd0), 64'(8));
    chk("idle_busy", busy[0] == 1'b0, 64'(busy[0]), 64'(0));

    // Order queue fills at 4; the 5th issue (ch3) is dropped.
    issue_vld[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue_ch[0] = (i < 4) ? 2'd1 : 2'd3;
      tick(1);
      if (i == 2) chk("q_rdy_at3", issue_rdy[0] == 1'b1, 64'(issue_rdy[0]), 64'(1));
      if (i == 3) chk("q_full_rdy", issue_rdy[0] == 1'b0, 64'(issue_rdy[0]), 64'(0));
      if (i == 4) chk("q_drop_rdy", issue_rdy[0] == 1'b0, 64'(issue_rdy[0]), 64'(0));
    end
    issue_ch[0] = 2'd0;
    push_words(0, 3, 4);
    tick(10);
    expect_pkt(0, 1);
    push_words(0, 1, 4);
    wait_exp(0, "q_first_pkt");
    tick(2);
    issue_vld[0] = 1'b0;
    chk("q_refill_rdy", issue_rdy[0] == 1'b0, 64'(issue_rdy[0]), 64'(0));
    for (int k = 0; k < 3; k++) begin
      expect_pkt(0, 1);
      push_words(0, 1, 4);
      wait_exp(0, "q_ch1_pkt");
    end
    expect_pkt(0, 0);
    push_words(0, 0, 4);
    wait_exp(0, "q_refill_pkt");
    tick(3);
    chk("q_empty_busy", busy[0] == 1'b0, 64'(busy[0]), 64'(0));
    chk("q_dropped_ch3", fq[0][3].size() == 4, 64'(fq[0][3].size()), 64'(4));
    discard(0, 3);

    // Round-robin: ch1 moves rr_ptr to 2; then {1,3} gives 3,1; then {0,2} gives 2,0.
    expect_pkt(1, 1);
    push_words(1, 1, 4);
    wait_exp(1, "rr_first");
    tick(2);
    expect_pkt(1, 3);
    expect_pkt(1, 1);
    push_words(1, 1, 4);
    push_words(1, 3, 4);
    wait_exp(1, "rr_pair_13");
    tick(2);
    expect_pkt(1, 2);
    expect_pkt(1, 0);
    push_words(1, 0, 4);
    push_words(1, 2, 4);
    wait_exp(1, "rr_pair_02");
    tick(3);
    chk("rr_idle_busy", busy[1] == 1'b0, 64'(busy[1]), 64'(0));

    // Head channel one word short holds off streaming; the final word starts it within 2 cycles.
    issue(0, 2);
    push_words(0, 2, 3);
    rd0 = rd_cnt[0];
    tick(100);
    chk("partial_no_rd", rd_cnt[0] == rd0, 64'(rd_cnt[0] - rd0), 64'(0));
    chk("partial_no_valid", m_tvalid[0] == 1'b0, 64'(m_tvalid[0]), 64'(0));
    expect_pkt(0, 2);
    push_words(0, 2, 1);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ch_rd[0] != '0) got = 1'b1;
    end
    chk("start_latency", got && lat <= 2, 64'(lat), 64'(2));
    wait_exp(0, "latency_pkt");
    tick(3);

    // Reset mid-packet with a second entry still queued.
    issue(0, 0);
    issue(0, 1);
    expect_pkt(0, 0);
    push_words(0, 0, 4);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ch_rd[0] != '0) got = 1'b1;
    end
    chk("reset_pkt_start", got, 64'(got), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", m_tvalid[0] == 1'b0, 64'(m_tvalid[0]), 64'(0));
    chk("arst_ch_rd", ch_rd[0] == '0, 64'(ch_rd[0]), 64'(0));
    chk("arst_busy", busy[0] == 1'b0, 64'(busy[0]), 64'(0));
    exp_q[0].delete();
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    chk("post_rst_rdy", issue_rdy[0] == 1'b1, 64'(issue_rdy[0]), 64'(1));
    chk("post_rst_busy", busy[0] == 1'b0, 64'(busy[0]), 64'(0));
    discard(0, 0);
    tick(10);
    issue(0, 1);
    expect_pkt(0, 1);
    push_words(0, 1, 4);
    wait_exp(0, "post_rst_pkt");
    tick(3);
    chk("final_busy", busy[0] == 1'b0, 64'(busy[0]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/paillier_result_gather.md
Name: paillier_result_gather

Overview:
- Collects completed Paillier results from the per-engine output FIFOs and streams them out on one valid/ready port.
- Sits between the BLOCK_COUNT engine result FIFOs and the AXI-FULL write path.
- Each result is N words of K bits and is emitted as one contiguous N-beat packet, tagged with its source channel.
- Two gather modes:
  - ORDERED: packets leave in task-issue order, using an internal channel-ID order queue.
  - ROUND-ROBIN: any channel holding a complete result is served fairly.

Parameters:
- CH, 29, number of engine channels (1..64).
- K, 128, data word width in bits.
- N, 32, words per result packet (power of two, >=2).
- ORDERED, 1, 1 = issue-order gathering, 0 = round-robin among ready channels.
- ID_DEPTH, 64, order-queue depth in entries (power of two).

Ports:
- clk, in, 1, single clock for all logic.
- rst_n, in, 1, asynchronous active-low reset.
- issue_vld, in, 1, a task has been issued to engine issue_ch.
- issue_ch, in, $clog2(CH), engine index of the issued task.
- issue_rdy, out, 1, order queue can accept an entry.
- ch_cnt, in, CH*($clog2(N)+1), flattened per-channel FIFO word counts; channel c occupies bits [c*W +: W], W=$clog2(N)+1.
- ch_dout, in, CH*K, flattened per-channel FIFO head words (first-word-fall-through).
- ch_rd, out, CH, one-hot pop strobe, one word per asserted cycle.
- m_tdata, out, K, output word.
- m_tvalid, out, 1, output word valid.
- m_tready, in, 1, downstream accepts.
- m_tlast, out, 1, last beat of a packet.
- m_tuser, out, $clog2(CH), source channel of the current packet.
- busy, out, 1, a packet is in flight or the order queue is non-empty.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Order queue emptied, FSM to SELECT, beat counter 0, round-robin pointer 0.
  - Outputs: issue_rdy=1, ch_rd=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, busy=0.
  - Reset mid-packet abandons the packet; no further pops or beats. Words left in the engine FIFOs are not this block's concern.
- Order queue (ORDERED=1):
  - Push when issue_vld && issue_rdy.
  - issue_rdy = !full, registered.
  - A push while full is dropped; issue_rdy=0 that cycle.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Read/write pointers wrap modulo ID_DEPTH.
- ORDERED=0: issue_rdy is tied to 1, issue_vld is ignored, and the queue is absent.
- FSM states: SELECT, STREAM.
- SELECT, ORDERED=1:
  - Head entry h is eligible when the queue is non-empty and ch_cnt[h] >= N.
  - Otherwise stay, even if other channels are complete; no overtaking.
- SELECT, ORDERED=0:
  - Choose the first channel c with ch_cnt[c] >= N, scanning from rr_ptr upward with wrap at CH.
  - None ready: stay.
- SELECT -> STREAM on an eligible channel:
  - Latch sel_ch and m_tuser <= sel_ch; clear the beat counter.
  - ORDERED=1: pop the queue. ORDERED=0: rr_ptr <= sel_ch+1 (wraps to 0 at CH).
  - Exactly one idle cycle in SELECT between packets.
- STREAM:
  - Single output register. Advance when (!m_tvalid || m_tready) && beat < N.
  - On advance: ch_rd[sel_ch]=1, m_tdata <= ch_dout[sel_ch], m_tvalid <= 1, m_tlast <= (beat==N-1), beat++.
  - With m_tready held high, throughput is 1 beat/cycle; first word is 1 cycle after entering STREAM.
- m_tvalid/m_tdata/m_tlast/m_tuser hold stable while m_tvalid && !m_tready.
- After the last beat is accepted (m_tvalid && m_tready && m_tlast):
  - m_tvalid <= 0 unless a new beat loads the same cycle; none can, so the bubble is required.
  - FSM returns to SELECT.
- ch_rd is never asserted for a channel other than sel_ch and never in SELECT.
- Safety: never pop a channel whose ch_cnt is 0. Eligibility requires >= N, so this cannot occur in legal use.
- busy = (state==STREAM) || m_tvalid || queue non-empty.

Test Plan:
- ORDERED=1, CH=4, N=4: issue ch 2 then 0; ch0 count 4 first, ch2 count 4 later -> no output until ch2 complete; then ch2 packet (4 beats, tuser=2, tlast on beat 3), bubble, ch0 packet.
- m_tready toggling 1,0,0,1 during a packet -> data/tlast held while stalled; ch_rd pulses exactly 4 times total; no duplicate or lost words.
- ORDERED=0, channels 1 and 3 both complete, rr_ptr=2 -> ch3 served first, then ch1; rr_ptr ends at 2.
- ID_DEPTH=4: push 5 issues with no drain -> issue_rdy=0 after the 4th; 5th dropped; one pop plus a simultaneous push keeps count at 4.
- Assert rst_n=0 at beat 2 of a packet -> m_tvalid, ch_rd, busy go 0 immediately (asynchronously); after release the FSM is in SELECT with the queue empty.
- ch_cnt=N-1 on the head channel for 100 cycles -> no ch_rd and no m_tvalid; at ch_cnt=N streaming starts within 2 cycles.
